// File: rtl/cpuif_passthrough_sequencer.sv
// rtl/cpuif_passthrough_sequencer.sv - command stream to passthrough cpuif master with in-order completion tracking
// One request register feeds the cpuif; a type-tag FIFO pairs acks with issued requests, and completions are buffered for the response stream.
module cpuif_passthrough_sequencer #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_is_wr,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wr_data,
  input  logic [DATA_WIDTH-1:0] cmd_wr_biten,
  output logic                  m_cpuif_req,
  output logic                  m_cpuif_req_is_wr,
  output logic [ADDR_WIDTH-1:0] m_cpuif_addr,
  output logic [DATA_WIDTH-1:0] m_cpuif_wr_data,
  output logic [DATA_WIDTH-1:0] m_cpuif_wr_biten,
  input  logic                  m_cpuif_req_stall_wr,
  input  logic                  m_cpuif_req_stall_rd,
  input  logic                  m_cpuif_rd_ack,
  input  logic                  m_cpuif_rd_err,
  input  logic [DATA_WIDTH-1:0] m_cpuif_rd_data,
  input  logic                  m_cpuif_wr_ack,
  input  logic                  m_cpuif_wr_err,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_is_wr,
  output logic                  rsp_err,
  output logic [DATA_WIDTH-1:0] rsp_rd_data,
  output logic                  protocol_err,
  output logic                  timeout
);

  localparam int PW      = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int DEPTH_P = 1 << PW;
  localparam int CW      = $clog2(MAX_OUTSTANDING + 1);
  localparam int TW      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(MAX_OUTSTANDING - 1);
  localparam logic [TW-1:0] TO_LIMIT = TW'(TIMEOUT_CYCLES);

  function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  logic                  r_req_full;
  logic                  r_req_is_wr;
  logic [ADDR_WIDTH-1:0] r_req_addr;
  logic [DATA_WIDTH-1:0] r_req_wr_data;
  logic [DATA_WIDTH-1:0] r_req_biten;
  logic [CW-1:0]         r_occ;

  logic                  r_tag_mem [DEPTH_P];
  logic [PW-1:0]         r_tag_wr, r_tag_rd;
  logic [CW-1:0]         r_tag_cnt;

  logic                  r_rsp_is_wr [DEPTH_P];
  logic                  r_rsp_err   [DEPTH_P];
  logic [DATA_WIDTH-1:0] r_rsp_data  [DEPTH_P];
  logic [PW-1:0]         r_rsp_wr, r_rsp_rd;
  logic [CW-1:0]         r_rsp_cnt;

  logic [TW-1:0]         r_to_cnt;
  logic                  r_timeout;
  logic                  r_protocol_err;

  logic                  w_stall, w_accept, w_cmd_hs, w_rsp_pop;
  logic [CW:0]           w_inflight;
  logic                  w_any_ack, w_tag_empty, w_head_is_wr, w_complete, w_mismatch;
  logic                  w_cpl_err, w_proto_evt, w_to_run;
  logic [DATA_WIDTH-1:0] w_cpl_data;
  logic [CW-1:0]         w_tag_cnt_nxt;

  assign m_cpuif_req       = r_req_full;
  assign m_cpuif_req_is_wr = r_req_is_wr;
  assign m_cpuif_addr      = r_req_addr;
  assign m_cpuif_wr_data   = r_req_wr_data;
  assign m_cpuif_wr_biten  = r_req_biten;

  assign w_stall    = r_req_is_wr ? m_cpuif_req_stall_wr : m_cpuif_req_stall_rd;
  assign w_accept   = r_req_full & ~w_stall;
  // The pending entry is counted so a refill never pushes issued work past the limit.
  assign w_inflight = {1'b0, r_occ} + {{CW{1'b0}}, r_req_full};
  assign cmd_ready  = ~rst & (~r_req_full | w_accept) & (w_inflight < (CW+1)'(MAX_OUTSTANDING));
  assign w_cmd_hs   = cmd_valid & cmd_ready;

  assign w_any_ack    = m_cpuif_rd_ack | m_cpuif_wr_ack;
  assign w_tag_empty  = (r_tag_cnt == '0);
  assign w_head_is_wr = r_tag_mem[r_tag_rd];
  assign w_complete   = w_any_ack & ~w_tag_empty;
  assign w_mismatch   = w_complete & ((m_cpuif_rd_ack & m_cpuif_wr_ack) |
                                      (m_cpuif_rd_ack & w_head_is_wr) |
                                      (m_cpuif_wr_ack & ~w_head_is_wr));
  assign w_cpl_err    = (m_cpuif_rd_ack & m_cpuif_rd_err) | (m_cpuif_wr_ack & m_cpuif_wr_err) | w_mismatch;
  assign w_cpl_data   = (~w_head_is_wr & m_cpuif_rd_ack) ? m_cpuif_rd_data : '0;
  assign w_proto_evt  = w_any_ack & (w_tag_empty | w_mismatch);
  assign w_tag_cnt_nxt = r_tag_cnt + CW'(w_accept) - CW'(w_complete);
  assign w_to_run     = ~w_any_ack & (w_tag_cnt_nxt != '0);

  assign rsp_valid   = (r_rsp_cnt != '0);
  assign w_rsp_pop   = rsp_valid & rsp_ready;
  assign rsp_is_wr   = rsp_valid & r_rsp_is_wr[r_rsp_rd];
  assign rsp_err     = rsp_valid & r_rsp_err[r_rsp_rd];
  assign rsp_rd_data = rsp_valid ? r_rsp_data[r_rsp_rd] : '0;

  assign protocol_err = r_protocol_err;
  assign timeout      = r_timeout;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_req_full    <= 1'b0;
      r_req_is_wr   <= 1'b0;
      r_req_addr    <= '0;
      r_req_wr_data <= '0;
      r_req_biten   <= '0;
    end else if (w_cmd_hs) begin
      r_req_full    <= 1'b1;
      r_req_is_wr   <= cmd_is_wr;
      r_req_addr    <= cmd_addr;
      r_req_wr_data <= cmd_wr_data;
      r_req_biten   <= cmd_wr_biten;
    end else if (w_accept) begin
      r_req_full    <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_occ <= '0;
    end else begin
      r_occ <= r_occ + CW'(w_accept) - CW'(w_rsp_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tag_wr  <= '0;
      r_tag_rd  <= '0;
      r_tag_cnt <= '0;
      for (int i = 0; i < DEPTH_P; i++) r_tag_mem[i] <= 1'b0;
    end else begin
      if (w_accept) begin
        r_tag_mem[r_tag_wr] <= r_req_is_wr;
        r_tag_wr            <= f_next(r_tag_wr);
      end
      if (w_complete) r_tag_rd <= f_next(r_tag_rd);
      r_tag_cnt <= w_tag_cnt_nxt;
    end
  end

  // Occupancy bounds the response FIFO, so pushes never need a full check.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_wr  <= '0;
      r_rsp_rd  <= '0;
      r_rsp_cnt <= '0;
      for (int i = 0; i < DEPTH_P; i++) begin
        r_rsp_is_wr[i] <= 1'b0;
        r_rsp_err[i]   <= 1'b0;
        r_rsp_data[i]  <= '0;
      end
    end else begin
      if (w_complete) begin
        r_rsp_is_wr[r_rsp_wr] <= w_head_is_wr;
        r_rsp_err[r_rsp_wr]   <= w_cpl_err;
        r_rsp_data[r_rsp_wr]  <= w_cpl_data;
        r_rsp_wr              <= f_next(r_rsp_wr);
      end
      if (w_rsp_pop) r_rsp_rd <= f_next(r_rsp_rd);
      r_rsp_cnt <= r_rsp_cnt + CW'(w_complete) - CW'(w_rsp_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_protocol_err <= 1'b0;
    end else if (w_proto_evt) begin
      r_protocol_err <= 1'b1;
    end
  end

  // Counting starts on the acceptance edge so the flag rises TIMEOUT_CYCLES after acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_to_cnt  <= '0;
      r_timeout <= 1'b0;
    end else if (w_to_run) begin
      if (r_to_cnt != TO_LIMIT) r_to_cnt <= r_to_cnt + TW'(1);
      if ((TIMEOUT_CYCLES != 0) && (r_to_cnt + TW'(1) == TO_LIMIT)) r_timeout <= 1'b1;
    end else begin
      r_to_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_cpuif_passthrough_sequencer.sv
// tb/tb_cpuif_passthrough_sequencer.sv - directed and randomized checks of cpuif_passthrough_sequencer
module tb_cpuif_passthrough_sequencer;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MO = 4;
  localparam int TO = 8;
  localparam int RND_CYCLES = 500;
  localparam int DRAIN_CYCLES = 80;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, cmd_valid, cmd_ready, cmd_is_wr;
  logic [AW-1:0] cmd_addr, m_cpuif_addr;
  logic [DW-1:0] cmd_wr_data, cmd_wr_biten, m_cpuif_wr_data, m_cpuif_wr_biten, m_cpuif_rd_data, rsp_rd_data;
  logic          m_cpuif_req, m_cpuif_req_is_wr, m_cpuif_req_stall_wr, m_cpuif_req_stall_rd;
  logic          m_cpuif_rd_ack, m_cpuif_rd_err, m_cpuif_wr_ack, m_cpuif_wr_err;
  logic          rsp_valid, rsp_ready, rsp_is_wr, rsp_err, protocol_err, timeout;

  cpuif_passthrough_sequencer #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_is_wr(cmd_is_wr),
    .cmd_addr(cmd_addr), .cmd_wr_data(cmd_wr_data), .cmd_wr_biten(cmd_wr_biten),
    .m_cpuif_req(m_cpuif_req), .m_cpuif_req_is_wr(m_cpuif_req_is_wr), .m_cpuif_addr(m_cpuif_addr),
    .m_cpuif_wr_data(m_cpuif_wr_data), .m_cpuif_wr_biten(m_cpuif_wr_biten),
    .m_cpuif_req_stall_wr(m_cpuif_req_stall_wr), .m_cpuif_req_stall_rd(m_cpuif_req_stall_rd),
    .m_cpuif_rd_ack(m_cpuif_rd_ack), .m_cpuif_rd_err(m_cpuif_rd_err), .m_cpuif_rd_data(m_cpuif_rd_data),
    .m_cpuif_wr_ack(m_cpuif_wr_ack), .m_cpuif_wr_err(m_cpuif_wr_err),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_is_wr(rsp_is_wr), .rsp_err(rsp_err),
    .rsp_rd_data(rsp_rd_data), .protocol_err(protocol_err), .timeout(timeout)
  );

  typedef struct { logic is_wr; logic [AW-1:0] addr; logic [DW-1:0] data; logic [DW-1:0] biten; } cmd_t;
  typedef struct { logic is_wr; int due; } pend_t;
  typedef struct { logic is_wr; logic err; logic [DW-1:0] data; } rsp_t;

  cmd_t  cmd_q[$];
  pend_t pend_q[$];
  rsp_t  exp_q[$];
  cmd_t  c;
  pend_t pe;
  rsp_t  er;
  int    occ;
  int    n_tests = 0;
  int    n_fail  = 0;
  logic  acc, exp_rdy, hs, e;
  logic [DW-1:0] d;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cmd_valid = 0; cmd_is_wr = 0; cmd_addr = '0; cmd_wr_data = '0; cmd_wr_biten = '0;
    m_cpuif_req_stall_wr = 0; m_cpuif_req_stall_rd = 0;
    m_cpuif_rd_ack = 0; m_cpuif_rd_err = 0; m_cpuif_rd_data = '0;
    m_cpuif_wr_ack = 0; m_cpuif_wr_err = 0; rsp_ready = 0;
  endtask

  task automatic push_cmd(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] dt, input logic [DW-1:0] b);
    cmd_is_wr = w; cmd_addr = a; cmd_wr_data = dt; cmd_wr_biten = b; cmd_valid = 1;
    #1;
    chk("push_cmd_ready", cmd_ready, 1);
    tick();
    cmd_valid = 0;
  endtask

  task automatic pop_rsp(input string tag, input logic w, input logic er_i, input logic [DW-1:0] dt);
    chk({tag, "_valid"}, rsp_valid, 1);
    chk({tag, "_is_wr"}, rsp_is_wr, w);
    chk({tag, "_err"}, rsp_err, er_i);
    chk({tag, "_data"}, rsp_rd_data, dt);
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    rst = 1;
    tick(); tick(); #1;
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_req", m_cpuif_req, 0);
    chk("rst_addr", m_cpuif_addr, 0);
    chk("rst_wdata", m_cpuif_wr_data, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_rd_data, 0);
    chk("rst_proto", protocol_err, 0);
    chk("rst_timeout", timeout, 0);
    rst = 0; #1;
    chk("post_rst_cmd_ready", cmd_ready, 1);
    tick();

    // Single write, unstalled
    push_cmd(1, 32'h10, 32'hA5A5_0000, '1);
    chk("wr_req", m_cpuif_req, 1);
    chk("wr_req_is_wr", m_cpuif_req_is_wr, 1);
    chk("wr_req_addr", m_cpuif_addr, 32'h10);
    chk("wr_req_data", m_cpuif_wr_data, 32'hA5A5_0000);
    chk("wr_req_biten", m_cpuif_wr_biten, 32'hFFFF_FFFF);
    tick();
    chk("wr_req_drop", m_cpuif_req, 0);
    tick();
    m_cpuif_wr_ack = 1;
    tick();
    m_cpuif_wr_ack = 0;
    pop_rsp("wr_rsp", 1, 0, 0);
    chk("wr_rsp_gone", rsp_valid, 0);

    // Stalled read
    m_cpuif_req_stall_rd = 1;
    push_cmd(0, 32'h20, 0, 0);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("stall_req%0d", i), m_cpuif_req, 1);
      chk($sformatf("stall_addr%0d", i), m_cpuif_addr, 32'h20);
      tick();
    end
    m_cpuif_req_stall_rd = 0;
    chk("stall_req_last", m_cpuif_req, 1);
    chk("stall_addr_last", m_cpuif_addr, 32'h20);
    tick();
    chk("stall_issued_once", m_cpuif_req, 0);
    m_cpuif_rd_ack = 1; m_cpuif_rd_err = 1; m_cpuif_rd_data = 32'h1234_5678;
    tick();
    m_cpuif_rd_ack = 0; m_cpuif_rd_err = 0; m_cpuif_rd_data = 0;
    pop_rsp("rd_err_rsp", 0, 1, 32'h1234_5678);
    chk("rd_single_rsp", rsp_valid, 0);

    // Outstanding limit with response backpressure
    cmd_is_wr = 0; cmd_addr = 32'h100; cmd_valid = 1; #1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("fill_ready%0d", k), cmd_ready, (k < 4));
      hs = cmd_ready;
      tick();
      if (hs) cmd_addr = cmd_addr + 4;
      #1;
    end
    for (int k = 0; k < 4; k++) begin
      m_cpuif_rd_ack = 1; m_cpuif_rd_data = 32'hD000_0000 + k;
      #1;
      chk($sformatf("full_ready%0d", k), cmd_ready, 0);
      tick();
    end
    m_cpuif_rd_ack = 0; m_cpuif_rd_data = 0; #1;
    chk("full_ready_rsp", cmd_ready, 0);
    chk("full_rsp_valid", rsp_valid, 1);
    chk("full_rsp0_data", rsp_rd_data, 32'hD000_0000);
    rsp_ready = 1;
    tick();
    rsp_ready = 0; #1;
    chk("ready_after_pop", cmd_ready, 1);
    tick();
    cmd_valid = 0;
    chk("fifth_req", m_cpuif_req, 1);
    chk("fifth_addr", m_cpuif_addr, 32'h110);
    tick();
    m_cpuif_rd_ack = 1; m_cpuif_rd_data = 32'hD000_0004;
    tick();
    m_cpuif_rd_ack = 0; m_cpuif_rd_data = 0;
    for (int k = 1; k <= 4; k++) pop_rsp($sformatf("order%0d", k), 0, 0, 32'hD000_0000 + k);

    // Type mismatch and ack with nothing outstanding
    chk("proto_clean", protocol_err, 0);
    push_cmd(1, 32'h30, 32'hDEAD_BEEF, 32'h0000_FFFF);
    tick();
    m_cpuif_rd_ack = 1; m_cpuif_rd_data = 32'h5555_5555;
    tick();
    m_cpuif_rd_ack = 0; m_cpuif_rd_data = 0;
    chk("mismatch_proto", protocol_err, 1);
    pop_rsp("mismatch_rsp", 1, 1, 0);
    m_cpuif_wr_ack = 1;
    tick();
    m_cpuif_wr_ack = 0;
    chk("empty_ack_no_rsp", rsp_valid, 0);
    chk("empty_ack_proto", protocol_err, 1);

    // Timeout
    push_cmd(0, 32'h40, 0, 0);
    chk("to_req", m_cpuif_req, 1);
    for (int i = 1; i <= 7; i++) begin
      tick();
      chk($sformatf("to_low%0d", i), timeout, 0);
    end
    tick();
    chk("to_high", timeout, 1);
    m_cpuif_rd_ack = 1; m_cpuif_rd_data = 32'hCAFE_0001;
    tick();
    m_cpuif_rd_ack = 0; m_cpuif_rd_data = 0;
    pop_rsp("to_late_rsp", 0, 0, 32'hCAFE_0001);
    chk("to_sticky", timeout, 1);

    // Reset with transactions in flight
    push_cmd(0, 32'h50, 0, 0);
    push_cmd(0, 32'h54, 0, 0);
    push_cmd(0, 32'h58, 0, 0);
    m_cpuif_rd_ack = 1; m_cpuif_rd_data = 32'h0BAD_0BAD;
    tick();
    m_cpuif_rd_ack = 0; m_cpuif_rd_data = 0;
    chk("pre_rst_rsp_valid", rsp_valid, 1);
    rst = 1;
    tick();
    rst = 0; #1;
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_req", m_cpuif_req, 0);
    chk("mid_rst_proto", protocol_err, 0);
    chk("mid_rst_timeout", timeout, 0);
    chk("mid_rst_cmd_ready", cmd_ready, 1);
    m_cpuif_rd_ack = 1;
    tick();
    m_cpuif_rd_ack = 0;
    chk("late_ack_proto", protocol_err, 1);
    chk("late_ack_no_rsp", rsp_valid, 0);
    rst = 1;
    tick();
    rst = 0;

    // Randomized traffic against an in-order slave and scoreboard
    occ = 0;
    for (int cyc = 0; cyc < RND_CYCLES + DRAIN_CYCLES; cyc++) begin
      if (!cmd_valid && cyc < RND_CYCLES && $urandom_range(0, 9) < 6) begin
        cmd_is_wr = $urandom_range(0, 1) == 1;
        cmd_addr = $urandom; cmd_wr_data = $urandom; cmd_wr_biten = $urandom;
        cmd_valid = 1;
      end
      m_cpuif_req_stall_wr = $urandom_range(0, 9) < 3;
      m_cpuif_req_stall_rd = $urandom_range(0, 9) < 3;
      rsp_ready = (cyc >= RND_CYCLES) ? 1'b1 : ($urandom_range(0, 9) < 6);
      m_cpuif_rd_ack = 0; m_cpuif_wr_ack = 0; m_cpuif_rd_err = 0; m_cpuif_wr_err = 0; m_cpuif_rd_data = 0;
      if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
        pe = pend_q.pop_front();
        e = $urandom_range(0, 3) == 0;
        d = $urandom;
        m_cpuif_rd_data = d;
        if (pe.is_wr) begin m_cpuif_wr_ack = 1; m_cpuif_wr_err = e; end
        else begin m_cpuif_rd_ack = 1; m_cpuif_rd_err = e; end
        er.is_wr = pe.is_wr; er.err = e; er.data = pe.is_wr ? '0 : d;
        exp_q.push_back(er);
      end
      #1;
      acc = m_cpuif_req && !(m_cpuif_req_is_wr ? m_cpuif_req_stall_wr : m_cpuif_req_stall_rd);
      exp_rdy = (!m_cpuif_req || acc) && (occ + int'(m_cpuif_req) < MO);
      chk("rnd_cmd_ready", cmd_ready, exp_rdy);
      if (acc) begin
        chk("rnd_req_has_cmd", cmd_q.size() != 0, 1);
        if (cmd_q.size() != 0) begin
          c = cmd_q.pop_front();
          chk("rnd_req_is_wr", m_cpuif_req_is_wr, c.is_wr);
          chk("rnd_req_addr", m_cpuif_addr, c.addr);
          chk("rnd_req_data", m_cpuif_wr_data, c.data);
          chk("rnd_req_biten", m_cpuif_wr_biten, c.biten);
        end
        pe.is_wr = m_cpuif_req_is_wr; pe.due = cyc + 1 + $urandom_range(0, 4);
        pend_q.push_back(pe);
        occ++;
      end
      if (rsp_valid && rsp_ready) begin
        chk("rnd_rsp_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          er = exp_q.pop_front();
          chk("rnd_rsp_is_wr", rsp_is_wr, er.is_wr);
          chk("rnd_rsp_err", rsp_err, er.err);
          chk("rnd_rsp_data", rsp_rd_data, er.data);
        end
        occ--;
      end
      hs = cmd_valid && cmd_ready;
      if (hs) begin
        c.is_wr = cmd_is_wr; c.addr = cmd_addr; c.data = cmd_wr_data; c.biten = cmd_wr_biten;
        cmd_q.push_back(c);
      end
      tick();
      if (hs) cmd_valid = 0;
    end
    chk("rnd_cmd_q_left", cmd_q.size(), 0);
    chk("rnd_pend_q_left", pend_q.size(), 0);
    chk("rnd_exp_q_left", exp_q.size(), 0);
    chk("rnd_rsp_valid_end", rsp_valid, 0);
    chk("rnd_proto_end", protocol_err, 0);
    chk("rnd_timeout_end", timeout, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
